mux_rr_stage: RTL and testbench

- Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshakes on every channel.
- Two modes:
  - fixed-select: the channel is chosen by `sel`.
  - round-robin: a rotating arbiter picks among the valid channels.
- Sits between board inputs (switches, PS/2 decoder, etc.) and display/LED sinks in the npc top.
- Next generation of the small 4-way 2-bit combinational mux.

---
 rtl/mux_rr_stage_pkg.sv | 18 +
 rtl/mux_rr_stage_if.sv | 31 +++
 rtl/mux_rr_stage_rr_pick.sv | 31 +++
 rtl/mux_rr_stage.sv | 83 ++++++++
 tb/tb_mux_rr_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_stage_pkg.sv
// Shared constants and helpers for the selector/arbiter stage.
// Mode encodings plus a constant-safe log2 for channel index widths.
package npc_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Smallest r with (1 << r) >= v; usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_stage_if.sv
// Handshake bundle between the board-side sources and the selector stage.
// master = the source/sink side, slave = the stage itself.
interface mux_rr_stage_if
    import npc_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
);
    localparam int SELW = clog2(N);

    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mux_rr_stage_rr_pick.sv
// Rotating priority picker: first requester after 'last', wrapping modulo N.
// Purely combinational.
module rr_pick
    import npc_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = SELW'((int'(last) + k) % N);
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_stage.sv
// N-channel W-bit selector with one registered output slot; fixed-select or
// round-robin grant, valid/ready on every channel, full 1 word/cycle throughput.
module mux_rr_stage
    import npc_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_stage_if.slave    bus
);

    localparam int SELW = clog2(N);

    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic [SELW-1:0]   r_out_ch;
    logic [SELW-1:0]   r_last;

    logic              w_accept;
    logic              w_rr_vld;
    logic [SELW-1:0]   w_rr_idx;
    logic              w_sel_vld;
    logic              w_gnt_vld;
    logic [SELW-1:0]   w_gnt_idx;
    logic              w_xfer;
    logic [W-1:0]      w_gnt_data;
    logic [N-1:0]      w_in_ready;

    rr_pick #(.N(N)) u_pick (
        .req       (bus.in_valid),
        .last      (r_last),
        .gnt_valid (w_rr_vld),
        .gnt_idx   (w_rr_idx)
    );

    // An out-of-range sel matches no channel, so it simply never grants.
    always_comb begin
        w_sel_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i)) w_sel_vld = bus.in_valid[i];
        end
    end

    assign w_accept  = !r_out_valid || bus.out_ready;
    assign w_gnt_vld = (bus.mode == MODE_RR) ? w_rr_vld : w_sel_vld;
    assign w_gnt_idx = (bus.mode == MODE_RR) ? w_rr_idx : bus.sel;
    assign w_xfer    = w_accept && w_gnt_vld;

    always_comb begin
        w_gnt_data = '0;
        w_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SELW'(i)) w_gnt_data = bus.in_data[i*W +: W];
            w_in_ready[i] = rst_n && w_xfer && (w_gnt_idx == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_last      <= SELW'(N - 1);
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                if (bus.mode == MODE_RR) r_last <= w_gnt_idx;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_stage.sv
// Scenario bench for mux_rr_stage (N=4, W=2): expected {ch,data} words are
// queued when a grant is expected and popped when the output word is consumed.
module tb_mux_rr_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [3:0] exp_q[$];
    logic [3:0] e;

    localparam logic [7:0] DATA = 8'b11_10_01_00;

    mux_rr_stage_if #(.N(4), .W(2)) bus ();

    mux_rr_stage #(.N(4), .W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0;
        bus.in_data = DATA; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 4'hF;
        bus.in_data = DATA; bus.out_ready = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 2'b00 || bus.out_ch !== 2'd0 || bus.in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got v=%b d=%b ch=%0d rdy=%b want v=0 d=00 ch=0 rdy=0000",
                         c, bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got %b want 0001", bus.in_ready);
        end
        exp_q.push_back({2'd0, 2'b00});
        @(posedge clk); #1;
        bus.in_valid = 4'h0;
        #1;
        checks++;
        if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
            failures++; $display("FAIL reset_first_word got v=%b want 1", bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
                failures++; $display("FAIL reset_first_word got %h want %h", {bus.out_ch, bus.out_data}, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        apply_reset();
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            failures++; $display("FAIL fixed_ready got %b want 0100", bus.in_ready);
        end
        exp_q.push_back({2'd2, 2'b10});
        @(posedge clk); #1;
        bus.in_valid = 4'b1011;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            failures++; $display("FAIL fixed_ready_off got %b want 0000", bus.in_ready);
        end
        checks++;
        if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
            failures++; $display("FAIL fixed_word got v=%b want 1", bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
                failures++; $display("FAIL fixed_word got %h want %h", {bus.out_ch, bus.out_data}, e);
            end
        end
        @(posedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL fixed_drain got v=%b want 0", bus.out_valid);
        end
    endtask

    // Shared by full and sparse round-robin: drive 'vmask', expect 'seq'.
    task automatic run_rr(input string name, input logic [3:0] vmask, input int n, input logic [1:0] seq[8]);
        apply_reset();
        bus.mode = 1'b1; bus.in_valid = vmask; bus.out_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            #1;
            if (c > 0) begin
                checks++;
                if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
                    failures++; $display("FAIL %s_bubble cyc=%0d got v=%b want 1", name, c, bus.out_valid);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_ch, bus.out_data} !== e) begin
                        failures++; $display("FAIL %s_word cyc=%0d got %h want %h", name, c, {bus.out_ch, bus.out_data}, e);
                    end
                end
            end
            checks++;
            if (bus.in_ready !== (4'b0001 << seq[c])) begin
                failures++; $display("FAIL %s_grant cyc=%0d got %b want %b", name, c, bus.in_ready, 4'b0001 << seq[c]);
            end
            exp_q.push_back({seq[c], seq[c]});
            @(posedge clk); #1;
        end
        bus.in_valid = 4'h0;
        #1;
        checks++;
        if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
            failures++; $display("FAIL %s_last got v=%b want 1", name, bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
                failures++; $display("FAIL %s_last got %h want %h", name, {bus.out_ch, bus.out_data}, e);
            end
        end
        @(posedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL %s_end got v=%b q=%0d want v=0 q=0", name, bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_rr();
        logic [1:0] seq[8];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        run_rr("rr", 4'hF, 8, seq);
    endtask

    task automatic test_sparse();
        logic [1:0] seq[8];
        seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        run_rr("sparse", 4'b1010, 4, seq);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010; bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_load got %b want 0010", bus.in_ready);
        end
        exp_q.push_back({2'd1, 2'b01});
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 4'hF; bus.sel = 2'(c); bus.mode = c[0];
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b01 || bus.out_ch !== 2'd1 || bus.in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d got v=%b d=%b ch=%0d rdy=%b want v=1 d=01 ch=1 rdy=0000",
                         c, bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        // Pointer untouched by the mode-0 load, so round-robin restarts at ch0.
        bus.mode = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
            failures++; $display("FAIL bp_release got v=%b want 1", bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
                failures++; $display("FAIL bp_release got %h want %h", {bus.out_ch, bus.out_data}, e);
            end
        end
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            failures++; $display("FAIL bp_next_grant got %b want 0001", bus.in_ready);
        end
        exp_q.push_back({2'd0, 2'b00});
        @(posedge clk); #1;
        bus.in_valid = 4'h0;
        #1;
        checks++;
        if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
            failures++; $display("FAIL bp_next_word got v=%b want 1", bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
                failures++; $display("FAIL bp_next_word got %h want %h", {bus.out_ch, bus.out_data}, e);
            end
        end
        @(posedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL bp_end got v=%b q=%0d want v=0 q=0", bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        bus.mode = 1'b1; bus.in_valid = 4'hF; bus.out_ready = 1'b0;
        #1;
        exp_q.push_back({2'd0, 2'b00});
        @(posedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin
            failures++; $display("FAIL mr_stall got v=%b rdy=%b want v=1 rdy=0000", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 2'b00 || bus.out_ch !== 2'd0 || bus.in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mr_async got v=%b d=%b ch=%0d rdy=%b want v=0 d=00 ch=0 rdy=0000",
                     bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            failures++; $display("FAIL mr_first_grant got %b want 0001", bus.in_ready);
        end
        exp_q.push_back({2'd0, 2'b00});
        @(posedge clk); #1;
        bus.in_valid = 4'h0;
        #1;
        checks++;
        if (!(bus.out_valid && bus.out_ready) || exp_q.size() == 0) begin
            failures++; $display("FAIL mr_word got v=%b want 1", bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
                failures++; $display("FAIL mr_word got %h want %h", {bus.out_ch, bus.out_data}, e);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fixed();
        test_rr();
        test_sparse();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
